keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Active scan driver for the 4x4 matrix keypad feeding the processor's keypad input port. It drives one-cold column strobes and samples the row returns. A detected key is debounced, translated to a hex key value and presented through a valid/ack handshake. The block ties up alongside the processor core and supplies the latched key value the core reads.

## Interface

- SCAN_DIV, 1000: clock cycles each column strobe dwells; minimum 2.
- DEBOUNCE, 4: consecutive agreeing samples required for press and release; minimum 1.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- row_in  in  4  keypad row returns, active-low (pulled up; 0 = key connects row to the strobed column).
- col_out  out  4  column strobes, one-cold active-low.
- key_code  out  16  {12'h000, hex key value}.
- key_valid  out  1  key_code holds an unread key.
- key_ack  in  1  consumer has read key_code; effective only while key_valid=1.
- key_pressed  out  1  a debounced key is currently held.
- overrun  out  1  a key was debounced while key_valid was still high.

## Operation

- Key map (row r, col c → value), row 0 first: 1,2,3,A / 4,5,6,B / 7,8,9,C / E(*),0,F(#),D.
- Dwell counter runs 0..SCAN_DIV-1. Sample point = last cycle of the dwell (count = SCAN_DIV-1). row_in is read only at sample points.
- If several rows read low, the lowest row index wins.
- SCAN:
  - col_out steps 1110→1101→1011→0111→1110, one step per dwell.
  - At a sample point with any row low, capture (row, active column). DEBOUNCE=1 goes straight to PRESS_OK. Otherwise set match count = 1 and go to DEBOUNCE_DN with the column frozen.
- DEBOUNCE_DN:
  - Column frozen. At each sample point, the captured row low → count+1. When count reaches DEBOUNCE, go to PRESS_OK.
  - Captured row high → return to SCAN on the next column.
- PRESS_OK (one cycle):
  - key_valid=0: load key_code with the mapped value and set key_valid.
  - key_valid=1: keep key_code and set overrun.
  - Go to HELD; key_pressed=1.
- HELD:
  - Column frozen. Count consecutive high samples of the captured row; any low sample resets the count to 0.
  - After DEBOUNCE consecutive highs, clear key_pressed and go to SCAN on the next column.
  - Other keys are ignored while in HELD.
- Handshake:
  - key_ack with key_valid=1 clears key_valid and overrun on the next edge. key_ack with key_valid=0 has no effect.
  - key_ack in the same cycle as PRESS_OK: the ack frees the slot. The new code loads, key_valid stays 1, and no overrun is raised.
- Reset has priority over every other event, including mid-debounce and mid-handshake.

## Timing

- Reset values: col_out=4'b1110, key_code=16'h0000, key_valid=0, key_pressed=0, overrun=0. State SCAN, column 0, all counters 0.
- All outputs are registered. col_out changes on the edge after a dwell's sample point.
- Press latency: key_valid rises (DEBOUNCE-1)*SCAN_DIV+2 cycles after the first low sample.
- Release: key_pressed falls (DEBOUNCE-1)*SCAN_DIV+1 cycles after the first confirming high sample.
- A key held across many dwells produces exactly one key_valid event. Auto-repeat is not provided.
- Column wraps 3→0 without a gap cycle.

## Test plan

Bench parameters: SCAN_DIV=4, DEBOUNCE=3.

- Reset: drive rst=0 for 2 cycles with row_in=4'b0000. Required: col_out=1110, key_code=0, key_valid=0, key_pressed=0, overrun=0. Release rst: col_out steps 1110→1101→1011→0111→1110 every 4 cycles.
- Single press: hold row 1 low whenever col_out=1011 (key "6"), keep it stable. Required: key_valid rises 10 cycles after the first sample, key_code=16'h0006, key_pressed=1. Pulse key_ack: key_valid and overrun are 0 next cycle.
- Bounce: make row 0 on col 0 read low, high, low, low, low at successive sample points. Required: the first low is rejected and scanning resumes. A later full 3-sample match yields key_code=16'h0001, emitted once.
- Simultaneous keys: rows 2 and 3 low on col 1 together. Required: key_code=16'h0008 (lower row wins). Press col 3 row 0 during HELD: ignored, no second key_valid.
- Overrun and ack collision: press "A" then "B" without ack. Required: key_code stays 16'h000A, overrun=1. Repeat with key_ack pulsed in the PRESS_OK cycle of the second key: key_code=16'h000B, key_valid=1, overrun=0.
- Reset mid-operation: assert rst during DEBOUNCE_DN and again during HELD. Required: all outputs return to their reset values on the next edge and scanning restarts at col_out=1110.

Source files
------------

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low matrix keypad, debounces press and release, and
// hands the translated hex key to the processor through a valid/ack slot.
module keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] key_code,
    output logic        key_valid,
    input  logic        key_ack,
    output logic        key_pressed,
    output logic        overrun
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DBN_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DBN_W-1:0] DBN_LAST = DBN_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE_DN,
        ST_PRESS_OK,
        ST_HELD
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [DBN_W-1:0] match_cnt, match_nxt;
    logic [1:0]       col, col_nxt;
    logic [1:0]       cap_row, cap_row_nxt;
    logic [3:0]       col_out_nxt;
    logic [15:0]      code_nxt;
    logic             valid_nxt, pressed_nxt, overrun_nxt;
    logic             sample, any_low, cap_low, advance;
    logic [1:0]       low_row;

    // Keypad legend; '*' and '#' are reported as E and F.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: key_map = 4'h1;
            4'b00_01: key_map = 4'h2;
            4'b00_10: key_map = 4'h3;
            4'b00_11: key_map = 4'hA;
            4'b01_00: key_map = 4'h4;
            4'b01_01: key_map = 4'h5;
            4'b01_10: key_map = 4'h6;
            4'b01_11: key_map = 4'hB;
            4'b10_00: key_map = 4'h7;
            4'b10_01: key_map = 4'h8;
            4'b10_10: key_map = 4'h9;
            4'b10_11: key_map = 4'hC;
            4'b11_00: key_map = 4'hE;
            4'b11_01: key_map = 4'h0;
            4'b11_10: key_map = 4'hF;
            default:  key_map = 4'hD;
        endcase
    endfunction

    assign sample  = (div_cnt == DIV_LAST);
    assign any_low = ~&row_in;
    assign cap_low = ~row_in[cap_row];

    always_comb begin
        if (!row_in[0])      low_row = 2'd0;
        else if (!row_in[1]) low_row = 2'd1;
        else if (!row_in[2]) low_row = 2'd2;
        else                 low_row = 2'd3;
    end

    // NOTE: every next-state value is defaulted to its current value first so
    // that no branch leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        match_nxt   = match_cnt;
        cap_row_nxt = cap_row;
        code_nxt    = key_code;
        valid_nxt   = key_valid;
        pressed_nxt = key_pressed;
        overrun_nxt = overrun;
        advance     = 1'b0;
        div_nxt     = sample ? '0 : div_cnt + DIV_W'(1);

        if (key_ack && key_valid) begin
            valid_nxt   = 1'b0;
            overrun_nxt = 1'b0;
        end

        case (state)
            ST_SCAN: begin
                if (sample) begin
                    if (any_low) begin
                        cap_row_nxt = low_row;
                        if (DEBOUNCE == 1) begin
                            state_nxt = ST_PRESS_OK;
                        end else begin
                            match_nxt = DBN_W'(1);
                            state_nxt = ST_DEBOUNCE_DN;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_DEBOUNCE_DN: begin
                if (sample) begin
                    if (!cap_low) begin
                        match_nxt = '0;
                        state_nxt = ST_SCAN;
                        advance   = 1'b1;
                    end else if (match_cnt == DBN_LAST) begin
                        match_nxt = '0;
                        state_nxt = ST_PRESS_OK;
                    end else begin
                        match_nxt = match_cnt + DBN_W'(1);
                    end
                end
            end
            ST_PRESS_OK: begin
                // An ack arriving in this very cycle frees the slot for the new key.
                if (!key_valid || key_ack) begin
                    code_nxt  = {12'h000, key_map(cap_row, col)};
                    valid_nxt = 1'b1;
                end else begin
                    overrun_nxt = 1'b1;
                end
                pressed_nxt = 1'b1;
                match_nxt   = '0;
                state_nxt   = ST_HELD;
            end
            default: begin
                if (sample) begin
                    if (cap_low) begin
                        match_nxt = '0;
                    end else if (match_cnt == DBN_LAST) begin
                        match_nxt   = '0;
                        pressed_nxt = 1'b0;
                        state_nxt   = ST_SCAN;
                        advance     = 1'b1;
                    end else begin
                        match_nxt = match_cnt + DBN_W'(1);
                    end
                end
            end
        endcase

        col_nxt     = advance ? col + 2'd1 : col;
        col_out_nxt = ~(4'b0001 << col_nxt);
    end

    // NOTE: registers use non-blocking assignments; reset is synchronous and
    // active-low, and takes priority over every other update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_SCAN;
            div_cnt     <= '0;
            match_cnt   <= '0;
            col         <= 2'd0;
            cap_row     <= 2'd0;
            col_out     <= 4'b1110;
            key_code    <= 16'h0000;
            key_valid   <= 1'b0;
            key_pressed <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            div_cnt     <= div_nxt;
            match_cnt   <= match_nxt;
            col         <= col_nxt;
            cap_row     <= cap_row_nxt;
            col_out     <= col_out_nxt;
            key_code    <= code_nxt;
            key_valid   <= valid_nxt;
            key_pressed <= pressed_nxt;
            overrun     <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and random key sequences against a keypad emulation plus a legend
// and latency reference computed from the keypad's documented behaviour.
module tb_keypad_scanner;

    localparam int SD  = 4;
    localparam int DB  = 3;
    localparam int LAT_PRESS   = (DB - 1) * SD + 2;
    localparam int LAT_RELEASE = (DB - 1) * SD + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] key_code;
    logic        key_valid;
    logic        key_ack;
    logic        key_pressed;
    logic        overrun;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk         (clk),
        .rst         (rst),
        .row_in      (row_in),
        .col_out     (col_out),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ack     (key_ack),
        .key_pressed (key_pressed),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          first_low  = -1;
    int          first_high = -1;
    int          arm_row    = -1;
    int          valid_rises = 0;
    logic        prev_valid = 1'b0;
    logic [15:0] pressed = 16'h0000;
    string       legend = "123A456B789CE0FD";

    function automatic logic [31:0] exp_code(input int k);
        int ch;
        ch = int'(legend[k]);
        if (ch >= 48 && ch <= 57) return 32'(ch - 48);
        return 32'(ch - 65 + 10);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Keypad emulation: a held key pulls its row low while its column is strobed.
    task automatic apply_rows();
        row_in = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col_out[c] && pressed[r*4+c]) row_in[r] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (key_valid && !prev_valid) valid_rises++;
        prev_valid = key_valid;
        apply_rows();
        if (cyc % SD == SD - 1) begin
            if (row_in != 4'hF && first_low < 0) first_low = cyc;
            if (arm_row >= 0 && row_in[arm_row] && first_high < 0) first_high = cyc;
        end
    endtask

    task automatic wait_sig(input int which, input logic level, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (((which == 0) ? key_valid : key_pressed) == level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_col"},     32'(col_out),     32'hE);
        check({tag, "_code"},    32'(key_code),    32'h0);
        check({tag, "_valid"},   32'(key_valid),   32'h0);
        check({tag, "_pressed"}, 32'(key_pressed), 32'h0);
        check({tag, "_overrun"}, 32'(overrun),     32'h0);
    endtask

    task automatic press_and_get(input int k, input string tag);
        bit ok;
        first_low = -1;
        pressed[k] = 1'b1;
        apply_rows();
        wait_sig(0, 1'b1, 60, ok);
        check({tag, "_valid_seen"}, 32'(ok), 32'h1);
        check({tag, "_latency"}, 32'(cyc - first_low), 32'(LAT_PRESS));
        check({tag, "_code"}, 32'(key_code), exp_code(k));
        check({tag, "_pressed"}, 32'(key_pressed), 32'h1);
    endtask

    task automatic release_key(input int k, input string tag);
        bit ok;
        first_high = -1;
        arm_row = k / 4;
        pressed[k] = 1'b0;
        apply_rows();
        wait_sig(1, 1'b0, 60, ok);
        check({tag, "_release_seen"}, 32'(ok), 32'h1);
        check({tag, "_release_lat"}, 32'(cyc - first_high), 32'(LAT_RELEASE));
        arm_row = -1;
    endtask

    task automatic ack(input string tag);
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
        check({tag, "_ack_valid"},   32'(key_valid), 32'h0);
        check({tag, "_ack_overrun"}, 32'(overrun),   32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int rises_before;
        int k;

        // Reset with every row pulled low.
        rst = 1'b0;
        key_ack = 1'b0;
        row_in = 4'h0;
        tick();
        row_in = 4'h0;
        tick();
        row_in = 4'h0;
        check_reset("reset");
        rst = 1'b1;
        cyc = 0;
        apply_rows();

        for (int i = 0; i < 16; i++) begin
            logic [3:0] exp_col;
            tick();
            exp_col = ~(4'b0001 << ((cyc / SD) % 4));
            check("scan_step", 32'(col_out), 32'(exp_col));
        end

        // Single stable press of "6".
        press_and_get(6, "key6");
        check("key6_overrun", 32'(overrun), 32'h0);
        ack("key6");
        release_key(6, "key6");

        // Bounce on key "1": one low sample, then high.
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (col_out == 4'b1110 && cyc % SD == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("bounce_align", 32'(ok), 32'h1);
        pressed[0] = 1'b1;
        apply_rows();
        repeat (SD) tick();
        check("bounce_frozen", 32'(col_out), 32'hE);
        pressed[0] = 1'b0;
        apply_rows();
        repeat (SD) tick();
        check("bounce_resume_col", 32'(col_out), 32'hD);
        check("bounce_no_valid", 32'(key_valid), 32'h0);
        check("bounce_no_pressed", 32'(key_pressed), 32'h0);
        press_and_get(0, "key1");
        ack("key1");
        rises_before = valid_rises;
        repeat (40) tick();
        check("key1_no_repeat", 32'(valid_rises), 32'(rises_before));
        check("key1_valid_low", 32'(key_valid), 32'h0);
        release_key(0, "key1");

        // Rows 2 and 3 together on column 1, then a foreign key during HELD.
        first_low = -1;
        pressed[9] = 1'b1;
        pressed[13] = 1'b1;
        apply_rows();
        wait_sig(0, 1'b1, 60, ok);
        check("multi_valid_seen", 32'(ok), 32'h1);
        check("multi_code", 32'(key_code), 32'h8);
        ack("multi");
        rises_before = valid_rises;
        pressed[3] = 1'b1;
        apply_rows();
        repeat (40) tick();
        check("held_ignore_rises", 32'(valid_rises), 32'(rises_before));
        check("held_ignore_valid", 32'(key_valid), 32'h0);
        check("held_still_pressed", 32'(key_pressed), 32'h1);
        pressed[3] = 1'b0;
        pressed[13] = 1'b0;
        release_key(9, "multi");

        // Overrun: "A" left unread, then "B".
        press_and_get(3, "keyA");
        release_key(3, "keyA");
        first_low = -1;
        pressed[7] = 1'b1;
        apply_rows();
        wait_sig(1, 1'b1, 60, ok);
        check("ovr_pressed_seen", 32'(ok), 32'h1);
        check("ovr_latency", 32'(cyc - first_low), 32'(LAT_PRESS));
        check("ovr_code_kept", 32'(key_code), 32'hA);
        check("ovr_valid", 32'(key_valid), 32'h1);
        check("ovr_flag", 32'(overrun), 32'h1);
        ack("ovr");
        release_key(7, "ovr");

        // Ack landing in the PRESS_OK cycle of the second key.
        press_and_get(3, "keyA2");
        release_key(3, "keyA2");
        first_low = -1;
        pressed[7] = 1'b1;
        apply_rows();
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (first_low >= 0 && cyc == first_low + LAT_PRESS - 1) begin
                ok = 1'b1;
                break;
            end
        end
        check("coll_align", 32'(ok), 32'h1);
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
        check("coll_code", 32'(key_code), 32'hB);
        check("coll_valid", 32'(key_valid), 32'h1);
        check("coll_overrun", 32'(overrun), 32'h0);
        check("coll_pressed", 32'(key_pressed), 32'h1);
        ack("coll");
        release_key(7, "coll");

        // Ack while nothing is pending changes nothing.
        ack("idle");

        // Random single keys.
        for (int n = 0; n < 6; n++) begin
            k = int'($urandom_range(0, 15));
            press_and_get(k, "rand");
            check("rand_overrun", 32'(overrun), 32'h0);
            ack("rand");
            release_key(k, "rand");
        end

        // Reset while debouncing a press of "5".
        first_low = -1;
        pressed[5] = 1'b1;
        apply_rows();
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (first_low >= 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("rst_dbn_align", 32'(ok), 32'h1);
        tick();
        tick();
        check("rst_dbn_frozen", 32'(col_out), 32'hD);
        rst = 1'b0;
        tick();
        check_reset("rst_dbn");
        pressed = 16'h0000;
        rst = 1'b1;
        cyc = 0;
        first_low = -1;
        apply_rows();
        repeat (SD) tick();
        check("rst_dbn_restart", 32'(col_out), 32'hD);
        check("rst_dbn_no_valid", 32'(key_valid), 32'h0);

        // Reset while a key is held and unread.
        press_and_get(5, "key5");
        rst = 1'b0;
        tick();
        check_reset("rst_held");
        pressed = 16'h0000;
        rst = 1'b1;
        cyc = 0;
        apply_rows();
        repeat (SD) tick();
        check("rst_held_restart", 32'(col_out), 32'hD);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
